// File: rtl/uart_frame_parser.sv
// uart_frame_parser: recovers 5-byte command frames (SYNC, CMD, DATA_HI, DATA_LO, CHK) from a UART byte stream
//   clk, rst       : clock and synchronous active-high reset
//   rx_valid       : one-cycle strobe qualifying rx_byte
//   rx_byte        : received byte
//   cmd_valid      : one-cycle pulse when a frame passes its checksum
//   cmd, cmd_data  : command and {DATA_HI, DATA_LO} of the last verified frame
//   chk_err        : one-cycle pulse on checksum mismatch
//   timeout_err    : one-cycle pulse when a frame stalls between bytes
//   err_count      : saturating count of chk_err and timeout_err events
//   state          : current FSM encoding for debug LEDs
module uart_frame_parser #(
    parameter logic [31:0] TIMEOUT_CLKS = 32'd200_000,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        cmd_valid,
    output logic [7:0]  cmd,
    output logic [15:0] cmd_data,
    output logic        chk_err,
    output logic        timeout_err,
    output logic [7:0]  err_count,
    output logic [2:0]  state
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_CMD = 3'd1,
        GET_HI  = 3'd2,
        GET_LO  = 3'd3,
        GET_CHK = 3'd4
    } state_t;

    state_t      r_state;
    logic [31:0] r_timer;
    logic [7:0]  r_sh_cmd, r_sh_hi, r_sh_lo;
    logic [7:0]  r_cmd, r_err_count;
    logic [15:0] r_cmd_data;
    logic        r_cmd_valid, r_chk_err, r_timeout_err;
    logic        w_chk_ok, w_timeout, w_err_sat;

    assign w_chk_ok  = (r_sh_cmd ^ r_sh_hi ^ r_sh_lo) == rx_byte;
    assign w_timeout = r_timer == TIMEOUT_CLKS - 32'd1;
    assign w_err_sat = r_err_count == 8'hFF;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_timer       <= '0;
            r_sh_cmd      <= '0;
            r_sh_hi       <= '0;
            r_sh_lo       <= '0;
            r_cmd         <= '0;
            r_cmd_data    <= '0;
            r_cmd_valid   <= 1'b0;
            r_chk_err     <= 1'b0;
            r_timeout_err <= 1'b0;
            r_err_count   <= '0;
        end else begin
            r_cmd_valid   <= 1'b0;
            r_chk_err     <= 1'b0;
            r_timeout_err <= 1'b0;
            if (r_state == IDLE) begin
                r_timer <= '0;
                if (rx_valid && rx_byte == SYNC_BYTE)
                    r_state <= GET_CMD;
            end else if (rx_valid) begin
                // a byte arriving on the boundary cycle takes priority over the timeout
                r_timer <= '0;
                case (r_state)
                    GET_CMD: begin r_sh_cmd <= rx_byte; r_state <= GET_HI; end
                    GET_HI:  begin r_sh_hi  <= rx_byte; r_state <= GET_LO; end
                    GET_LO:  begin r_sh_lo  <= rx_byte; r_state <= GET_CHK; end
                    GET_CHK: begin
                        r_state <= IDLE;
                        if (w_chk_ok) begin
                            r_cmd       <= r_sh_cmd;
                            r_cmd_data  <= {r_sh_hi, r_sh_lo};
                            r_cmd_valid <= 1'b1;
                        end else begin
                            r_chk_err <= 1'b1;
                            if (!w_err_sat)
                                r_err_count <= r_err_count + 8'd1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end else if (w_timeout) begin
                r_state       <= IDLE;
                r_timer       <= '0;
                r_timeout_err <= 1'b1;
                if (!w_err_sat)
                    r_err_count <= r_err_count + 8'd1;
            end else begin
                r_timer <= r_timer + 32'd1;
            end
        end
    end

    assign cmd_valid   = r_cmd_valid;
    assign cmd         = r_cmd;
    assign cmd_data    = r_cmd_data;
    assign chk_err     = r_chk_err;
    assign timeout_err = r_timeout_err;
    assign err_count   = r_err_count;
    assign state       = r_state;
endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser: directed and randomized checks of uart_frame_parser against a byte-count frame model
module tb_uart_frame_parser;
    localparam int TMO = 16;
    localparam logic [7:0] SYNC = 8'hA5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        cmd_valid, chk_err, timeout_err;
    logic [7:0]  cmd, err_count;
    logic [15:0] cmd_data;
    logic [2:0]  state;

    uart_frame_parser #(.TIMEOUT_CLKS(32'd16), .SYNC_BYTE(SYNC)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .cmd_valid(cmd_valid), .cmd(cmd), .cmd_data(cmd_data),
        .chk_err(chk_err), .timeout_err(timeout_err),
        .err_count(err_count), .state(state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the state is simply how many frame bytes have been collected so far.
    int          n = 0;
    int          gap = 0;
    logic [7:0]  fb [5];
    logic        started = 1'b0;
    logic        e_cv = 1'b0, e_ce = 1'b0, e_te = 1'b0;
    logic [7:0]  e_cmd = 8'h00, e_err = 8'h00;
    logic [15:0] e_data = 16'h0000;

    always @(posedge clk) begin
        started = 1'b1;
        e_cv = 1'b0;
        e_ce = 1'b0;
        e_te = 1'b0;
        if (rst) begin
            n = 0; gap = 0; e_cmd = 8'h00; e_data = 16'h0000; e_err = 8'h00;
        end else if (rx_valid) begin
            gap = 0;
            if (n == 0) begin
                if (rx_byte == SYNC) n = 1;
            end else begin
                fb[n] = rx_byte;
                n++;
                if (n == 5) begin
                    n = 0;
                    if ((fb[1] ^ fb[2] ^ fb[3]) == fb[4]) begin
                        e_cv = 1'b1; e_cmd = fb[1]; e_data = {fb[2], fb[3]};
                    end else begin
                        e_ce = 1'b1; e_err = (e_err == 8'hFF) ? 8'hFF : e_err + 8'd1;
                    end
                end
            end
        end else if (n > 0) begin
            gap++;
            if (gap == TMO) begin
                n = 0; gap = 0; e_te = 1'b1;
                e_err = (e_err == 8'hFF) ? 8'hFF : e_err + 8'd1;
            end
        end
    end

    int n_cv = 0, n_ce = 0, n_te = 0;

    always @(negedge clk) begin
        if (started) begin
            check("cmd_valid", {31'd0, cmd_valid}, {31'd0, e_cv});
            check("chk_err", {31'd0, chk_err}, {31'd0, e_ce});
            check("timeout_err", {31'd0, timeout_err}, {31'd0, e_te});
            check("cmd", {24'd0, cmd}, {24'd0, e_cmd});
            check("cmd_data", {16'd0, cmd_data}, {16'd0, e_data});
            check("err_count", {24'd0, err_count}, {24'd0, e_err});
            check("state", {29'd0, state}, n[31:0]);
            if (cmd_valid) n_cv++;
            if (chk_err) n_ce++;
            if (timeout_err) n_te++;
        end
    end

    task automatic idle(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l, input logic [7:0] k);
        send(SYNC); send(c); send(h); send(l); send(k);
    endtask

    task automatic clr;
        n_cv = 0; n_ce = 0; n_te = 0;
    endtask

    task automatic pulse_rst;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] c, h, l;
        idle(2);
        rst = 1'b0;
        check("rst_state", {29'd0, state}, 32'd0);
        check("rst_cmd", {24'd0, cmd}, 32'd0);
        check("rst_data", {16'd0, cmd_data}, 32'd0);
        check("rst_err", {24'd0, err_count}, 32'd0);

        clr; frame(8'h01, 8'h12, 8'h34, 8'h27); idle(2);
        check("good_cv_count", n_cv, 1);
        check("good_err_pulses", n_ce + n_te, 0);
        check("good_cmd", {24'd0, cmd}, 32'h01);
        check("good_data", {16'd0, cmd_data}, 32'h1234);
        check("good_model_data", {16'd0, e_data}, 32'h1234);
        check("good_err", {24'd0, err_count}, 32'd0);

        clr; frame(8'h01, 8'h12, 8'h34, 8'h00); idle(2);
        check("bad_ce_count", n_ce, 1);
        check("bad_cv_count", n_cv, 0);
        check("bad_cmd_held", {24'd0, cmd}, 32'h01);
        check("bad_data_held", {16'd0, cmd_data}, 32'h1234);
        check("bad_err", {24'd0, err_count}, 32'd1);
        check("bad_model_err", {24'd0, e_err}, 32'd1);
        check("bad_state", {29'd0, state}, 32'd0);

        clr; send(8'h00); send(8'hFF); send(8'h5A); frame(8'h7F, 8'h00, 8'hFF, 8'h80); idle(2);
        check("garbage_err_pulses", n_ce + n_te, 0);
        check("garbage_cv_count", n_cv, 1);
        check("garbage_cmd", {24'd0, cmd}, 32'h7F);
        check("garbage_data", {16'd0, cmd_data}, 32'h00FF);

        pulse_rst;
        clr; send(SYNC); send(8'h01); idle(16); frame(8'h02, 8'h00, 8'h01, 8'h03); idle(2);
        check("tmo_te_count", n_te, 1);
        check("tmo_err", {24'd0, err_count}, 32'd1);
        check("tmo_cv_count", n_cv, 1);
        check("tmo_cmd", {24'd0, cmd}, 32'h02);
        check("tmo_data", {16'd0, cmd_data}, 32'h0001);

        clr;
        send(SYNC); idle(15); send(8'h05); idle(15); send(8'h06);
        idle(15); send(8'h07); idle(15); send(8'h04); idle(2);
        check("edge_te_count", n_te, 0);
        check("edge_cv_count", n_cv, 1);
        check("edge_data", {16'd0, cmd_data}, 32'h0607);

        clr; send(SYNC); send(8'h01); send(8'h12);
        rst = 1'b1; rx_valid = 1'b1; rx_byte = SYNC;
        @(posedge clk); #1;
        rst = 1'b0; rx_valid = 1'b0;
        check("rst_mid_state", {29'd0, state}, 32'd0);
        frame(8'h03, 8'h00, 8'h00, 8'h03); idle(2);
        check("rst_mid_err_pulses", n_ce + n_te, 0);
        check("rst_mid_cv", n_cv, 1);
        check("rst_mid_cmd", {24'd0, cmd}, 32'h03);
        check("rst_mid_data", {16'd0, cmd_data}, 32'h0000);
        check("rst_mid_err", {24'd0, err_count}, 32'd0);

        clr; frame(8'h10, 8'h20, 8'h30, 8'h00); frame(8'h11, 8'h22, 8'h33, 8'h00); idle(2);
        check("b2b_cv_count", n_cv, 2);
        check("b2b_cmd", {24'd0, cmd}, 32'h11);

        for (int i = 0; i < 300; i++) frame(8'h01, 8'h02, 8'h03, 8'hFF);
        idle(2);
        check("sat_err", {24'd0, err_count}, 32'hFF);
        check("sat_model_err", {24'd0, e_err}, 32'hFF);

        pulse_rst;
        for (int i = 0; i < 600; i++) begin
            c = 8'($urandom); h = 8'($urandom); l = 8'($urandom);
            case ($urandom_range(0, 9))
                0, 1, 2: frame(c, h, l, c ^ h ^ l);
                3:       frame(c, h, l, 8'($urandom));
                4:       begin send(SYNC); send(c); idle($urandom_range(14, 18)); end
                5:       send(SYNC);
                6:       if ($urandom_range(0, 9) == 0) pulse_rst; else send(8'($urandom));
                default: begin send(8'($urandom)); idle($urandom_range(0, 3)); end
            endcase
            if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 17));
        end
        idle(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
